// File: rtl/ripple_carry_adder_structural_pkg.sv
// Shared width defaults for the ripple-carry and carry-select adders
// and their benches.
package ripple_carry_adder_structural_pkg;

  localparam int IWL_DEF = 4;
  localparam int OWL_DEF = 5;

endpackage

// File: rtl/ripple_carry_adder_structural_if.sv
// Operand/result bundle of the registered ripple-carry adder.
// The master drives operands; the slave returns sum and carry.
interface ripple_carry_adder_structural_if
  import ripple_carry_adder_structural_pkg::*;
#(
  parameter int IWL = IWL_DEF,
  parameter int OWL = OWL_DEF
);

  logic [IWL-1:0] a;
  logic [IWL-1:0] b;
  logic [OWL-1:0] s;
  logic           cout;

  modport master (
    output a,
    output b,
    input  s,
    input  cout
  );

  modport slave (
    input  a,
    input  b,
    output s,
    output cout
  );

endinterface

// File: rtl/ripple_carry_adder_structural_full_adder.sv
// Single-bit full adder, gate-level expressions only.
// This is the cell the ripple chain is built from.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_structural.sv
// Unsigned ripple-carry adder built from a chain of full_adder
// cells, with a registered sum and carry-out.
module ripple_carry_adder_structural
  import ripple_carry_adder_structural_pkg::*;
#(
  parameter int IWL = IWL_DEF,
  parameter int OWL = OWL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  ripple_carry_adder_structural_if.slave bus
);

  if (OWL < IWL || IWL < 1) begin : g_bad_cfg
    $error("ripple_carry_adder_structural: need IWL >= 1 and OWL >= IWL");
  end

  logic [IWL:0]   c;
  logic [IWL-1:0] t;
  logic [OWL-1:0] s_next;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < IWL; i++) begin : g_fa
    full_adder u_fa (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (c[i]),
      .s    (t[i]),
      .cout (c[i+1])
    );
  end

  // With OWL == IWL the carry is dropped from s and survives on cout only.
  if (OWL == IWL) begin : g_trunc
    assign s_next = t;
  end else if (OWL == IWL + 1) begin : g_exact
    assign s_next = {c[IWL], t};
  end else begin : g_zext
    assign s_next = {{(OWL-IWL-1){1'b0}}, c[IWL], t};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s    <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.s    <= s_next;
      bus.cout <= c[IWL];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_structural.sv
// Directed and exhaustive bench for the registered ripple-carry adder,
// default 4/5 instance plus an 8/10 spot-check instance.
module tb_ripple_carry_adder_structural;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  ripple_carry_adder_structural_if #(.IWL(4), .OWL(5))  bus ();
  ripple_carry_adder_structural_if #(.IWL(8), .OWL(10)) wide ();

  ripple_carry_adder_structural #(.IWL(4), .OWL(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ripple_carry_adder_structural #(.IWL(8), .OWL(10)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wide.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply(
    input string    tag,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [4:0] exp_s,
    input logic       exp_c
  );
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    chk({tag, ".s"}, 32'(bus.s), 32'(exp_s));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(exp_c));
  endtask

  initial begin
    logic [4:0] sum;
    logic [3:0] ta;
    logic [3:0] tb;

    rst_n  = 1'b0;
    bus.a  = 4'b1111;
    bus.b  = 4'b1111;
    wide.a = 8'd255;
    wide.b = 8'd255;

    #2;
    chk("rst_async.s", 32'(bus.s), 32'd0);
    chk("rst_async.cout", 32'(bus.cout), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held.s", 32'(bus.s), 32'd0);
    chk("rst_held.cout", 32'(bus.cout), 32'd0);
    chk("rst_held.wide", 32'(wide.s), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    apply("zero",     4'b0000, 4'b0000, 5'd0,  1'b0);
    chk("wide.s", 32'(wide.s), 32'd510);
    chk("wide.cout", 32'(wide.cout), 32'd1);
    chk("wide.s9", 32'(wide.s[9]), 32'd0);

    apply("full",     4'b1111, 4'b1111, 5'd30, 1'b1);
    apply("mixed",    4'b1110, 4'b0111, 5'd21, 1'b1);
    apply("alt",      4'b1010, 4'b0101, 5'd15, 1'b0);
    apply("msb",      4'b1000, 4'b1000, 5'd16, 1'b1);

    // Back-to-back operands; mid-cycle input changes must not leak through.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ta = 4'(3 * i + 2);
      tb = 4'(5 * i + 7);
      bus.a = ta;
      bus.b = tb;
      #1;
      chk("lat.hold", 32'(bus.s), (i == 0) ? 32'd16 : 32'(sum));
      sum = 5'(ta) + 5'(tb);
      @(posedge clk);
      #1;
      chk("lat.s", 32'(bus.s), 32'(sum));
      chk("lat.cout", 32'(bus.cout), 32'(sum[4]));
    end

    @(negedge clk);
    bus.a = 4'd9;
    bus.b = 4'd9;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.s", 32'(bus.s), 32'd0);
    chk("midrst.cout", 32'(bus.cout), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.s", 32'(bus.s), 32'd18);
    chk("post_rst.cout", 32'(bus.cout), 32'd1);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        bus.a = 4'(x);
        bus.b = 4'(y);
        sum = 5'(x + y);
        @(posedge clk);
        #1;
        chk("sweep.s", 32'(bus.s), 32'(sum));
        chk("sweep.cout", 32'(bus.cout), 32'(sum[4]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder_structural.md
# ripple_carry_adder_structural

Parameterised unsigned adder built as a structural chain of single-bit full adders, with a registered output stage. It takes two IWL-bit operands and produces their full-width sum plus a carry-out flag. It serves as the reference ripple-carry datapath element, the baseline against which the carry-select variants are compared.

## Interface

Parameters:
- IWL, default 4: input word length (bits per operand); must be ≥ 1.
- OWL, default 5: output word length of `s`; must be ≥ IWL.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; **asynchronous, active-low**. One clock domain only.
- a  input  IWL  operand A, unsigned.
- b  input  IWL  operand B, unsigned.
- s  output  OWL  registered sum, unsigned.
- cout  output  1  registered carry-out of the IWL-bit addition.

## Operation

- The combinational core is a chain of IWL full adders.
  - Stage i takes a[i], b[i] and c[i].
  - It produces sum bit t[i] and carry c[i+1] = a[i]b[i] | c[i](a[i]^b[i]).
  - The chain input c[0] is tied to 0; there is no carry-in port.
  - Carry ripples from stage 0 to stage IWL-1.
  - No lookahead, no carry-select, no behavioural `+` operator in the datapath.
- Output formation:
  - The full sum is {c[IWL], t[IWL-1:0]}.
  - If OWL > IWL+1, the upper bits of s are zero-filled.
  - If OWL == IWL+1, s[IWL] = c[IWL].
  - If OWL == IWL, s = t and the carry appears only on cout (truncated sum).
  - cout = c[IWL] in all configurations.
- Arithmetic:
  - Unsigned modulo 2^IWL for the low bits.
  - No overflow flag beyond cout.
  - No signed interpretation.

## Timing

- Latency is 1 cycle. Operands sampled at rising edge N appear on s/cout after edge N.
  - Throughput is one addition per cycle.
  - There is no handshake; operands are assumed valid every cycle.
- Reset values:
  - While rst_n = 0, s = 0 and cout = 0 immediately, without waiting for clk.
  - Reset asserted mid-operation discards the in-flight result.
  - The first valid result after reset release is the one sampled at the first rising edge with rst_n = 1.
- Outputs change only on the rising edge of clk or on reset assertion. They never glitch with input changes.
- Critical path is the IWL-stage carry ripple plus register setup. The design must close timing at IWL = 32 for the team's standard clock.
- Input changes between edges have no effect until the next edge.

## Structure

- Sub-module `full_adder`: ports a, b, cin → s, cout, purely combinational, gate-level expressions.
- Top level:
  - A generate loop instantiates IWL `full_adder` instances.
  - Tie-off for c[0].
  - Zero-extension logic for s.
  - One always block with async active-low reset registering s and cout.
- Shared package:
  - Default width constants (IWL = 4, OWL = 5), so the RCA and CSA blocks and their benches agree.
  - No typedefs needed.
- Elaboration-time check: flag an error if OWL < IWL or IWL < 1.

## Test plan

1. Reset: hold rst_n = 0 with a = 4'b1111, b = 4'b1111 → s = 5'b00000, cout = 0, asynchronously and with no clock edge needed.
2. Zero / full-carry operands, one edge after release:
   - a = 4'b0000, b = 4'b0000 → s = 5'b00000, cout = 0.
   - a = 4'b1111, b = 4'b1111 → s = 5'b11110 (30), cout = 1.
3. Mixed operands and no-carry worst ripple:
   - a = 4'b1110, b = 4'b0111 → s = 5'b10101 (21), cout = 1.
   - a = 4'b1010, b = 4'b0101 → s = 5'b01111 (15), cout = 0.
4. Single MSB carry: a = 4'b1000, b = 4'b1000 → s = 5'b10000 (16), cout = 1.
5. Latency and mid-stream reset: apply a new operand pair every cycle and check each result appears exactly one edge later. Then pulse rst_n low between edges → s/cout drop to 0 at once, and the next edge after release shows the current operands' sum.
6. Exhaustive and parameter sweep:
   - All 256 operand pairs at IWL = 4 checked against a behavioural a+b.
   - Spot check at IWL = 8, OWL = 10: a = 255, b = 255 → s = 10'd510, cout = 1, s[9] = 0.
